instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage. Holds the PC, issues one-at-a-time requests to instruction memory, and captures each returned word in an instruction register.
//  Presents {instruction, inst_pc} to decode / immediate_decoder via a valid/ready handshake.
//  Accepts PC redirects from the branch/jump unit (target = PC + decoded immediate).
//  Non-pipelined: at most one outstanding memory request.
// PARAMETERS
//  XLEN      64      PC / address width
//  RESET_PC  64'h0   PC value loaded on reset
// PORTS
//  clk             in   1     single clock, rising edge
//  reset           in   1     asynchronous, active-high
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request this cycle
//  imem_req_addr   out  XLEN  fetch address (= current PC)
//  imem_rsp_valid  in   1     response word valid (>=1 cycle after accept)
//  imem_rsp_data   in   32    fetched instruction word
//  redirect_valid  in   1     load new PC (branch taken / jal / jalr)
//  redirect_pc     in   XLEN  redirect target
//  inst_valid      out  1     instruction register holds a valid instruction
//  inst_ready      in   1     decode consumes instruction this cycle
//  instruction     out  32    instruction register to decoder
//  inst_pc         out  XLEN  PC of the instruction in the register
//  misalign_fault  out  1     present only with MISALIGN_CHECK_EN
// BEHAVIOUR
//  Reset values:
//   - pc = inst_pc = RESET_PC; instruction = 32'h00000013 (nop)
//   - inst_valid = 0; imem_req_valid = 0; drop = 0; state = FETCH
//  FSM states:
//   - FETCH: req_valid = 1, req_addr = pc. On req_ready -> WAIT.
//   - WAIT: req_valid = 0. On rsp_valid and !drop: IR <= rsp_data, inst_pc <= pc, pc <= pc+4, inst_valid <= 1 -> HOLD.
//   - HOLD: inst_valid = 1, no request. On inst_valid & inst_ready: inst_valid <= 0 -> FETCH.
//  Latency: first request is 1 cycle after reset release. Instruction visible the cycle after rsp_valid. Minimum 3 cycles per instruction with a 1-cycle memory.
//  Redirect has priority over every other event; pc <= redirect_pc on the next edge.
//   - FETCH, no accept: stay FETCH; the new address is driven next cycle.
//   - FETCH, same-cycle accept: drop <= 1 -> WAIT (stale request is in flight).
//   - WAIT: drop <= 1. Next rsp_valid is discarded (IR unchanged); drop <= 0 -> FETCH.
//   - HOLD: inst_valid <= 0 -> FETCH. A same-cycle inst_ready still counts as consumed; the redirect applies.
//  rsp_valid in FETCH or HOLD (nothing outstanding) is ignored.
//  PC arithmetic is modulo 2^XLEN: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
//  IR holds stable while inst_valid & !inst_ready; no new request is issued in HOLD.
//  Reset asserted mid-operation returns to reset values immediately. A late response from the aborted request arrives in FETCH and is ignored.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined:
//   - redirect_pc[1:0] != 0 -> pc <= redirect_pc, state FAULT, misalign_fault = 1, no requests.
//   - FAULT is left only by reset or an aligned redirect (-> FETCH, fault cleared).
//  MISALIGN_CHECK_EN undefined:
//   - port absent; redirect_pc[1:0] forced to 2'b00.
// STRUCTURE
//  Shared defs include riscv_defs.vh:
//   - XLEN default, NOP_INST = 32'h00000013, INST_W = 32
//   - FSM state encodings FETCH/WAIT/HOLD/FAULT (2 bits)
//  Sub-module pc_register:
//   - XLEN-wide register with async reset to RESET_PC; load (redirect) and increment (+4) enables; redirect wins.
//  FSM, drop flag and IR live in instruction_fetch_unit.
// TESTING
//  1 Reset, RESET_PC=0, 1-cycle memory returns 32'h03200293 -> req_addr 0; instruction = 32'h03200293, inst_pc = 0; next req_addr = 4.
//  2 inst_ready=0 for 5 cycles after inst_valid -> instruction/inst_pc stable, imem_req_valid = 0 throughout; then ready=1 -> req_addr = 4 next cycle.
//  3 Redirect to 64'h40 while in WAIT for addr 8 -> the addr-8 response never raises inst_valid; next req_addr = 64'h40.
//  4 Redirect to 64'h100 in the same cycle as inst_valid&inst_ready -> instruction consumed once; next req_addr = 64'h100, not pc+4.
//  5 Redirect to 64'h42: with MISALIGN_CHECK_EN -> misalign_fault = 1, no requests until redirect to 64'h80; without it -> req_addr = 64'h40.
//  6 Reset asserted in WAIT, late rsp_valid after release -> discarded; req_addr = RESET_PC; inst_valid = 0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// ============================================================================
// Module  : instruction_fetch_unit_pkg
// Brief   : Shared definitions for the fetch stage (widths, NOP, FSM states).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_unit_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int INST_W       = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
// ============================================================================
// Module  : instruction_fetch_unit_if
// Brief   : Memory, redirect and decode handshake bundle of the fetch stage.
//           misalign_fault exists only when MISALIGN_CHECK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] instruction;
  logic [XLEN-1:0]   inst_pc;
`ifdef MISALIGN_CHECK_EN
  logic              misalign_fault;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc, misalign_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc, misalign_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
`else
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
`endif

endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_register.sv
// ============================================================================
// Module  : instruction_fetch_unit_pc_register
// Brief   : Program counter with redirect load and +4 increment (load wins).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit_pc_register #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            load,
  input  wire logic [XLEN-1:0] load_pc,
  input  wire logic            incr,
  output logic      [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Increment wraps modulo 2^XLEN by construction.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (incr) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module  : instruction_fetch_unit
// Brief   : Non-pipelined fetch stage: one outstanding imem request, IR and
//           valid/ready hand-off to decode. Option macro: MISALIGN_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  instruction_fetch_unit_if.master  bus
);

  fetch_state_e      state_d, state_q;
  logic              drop_d, drop_q;
  logic              req_valid_d, req_valid_q;
  logic              inst_valid_d, inst_valid_q;
  logic [INST_W-1:0] ir_d, ir_q;
  logic [XLEN-1:0]   inst_pc_d, inst_pc_q;

  logic              accept;
  logic              pc_load;
  logic              pc_incr;
  logic              redirect_bad;
  logic [XLEN-1:0]   redirect_target;
  logic [XLEN-1:0]   pc;

`ifdef MISALIGN_CHECK_EN
  assign redirect_bad    = is_misaligned(bus.redirect_pc[1:0]);
  assign redirect_target = bus.redirect_pc;
`else
  assign redirect_bad    = 1'b0;
  assign redirect_target = bus.redirect_pc & ~XLEN'(3);
`endif

  assign accept  = (state_q == ST_FETCH) && req_valid_q && bus.imem_req_ready;
  assign pc_load = bus.redirect_valid;

  instruction_fetch_unit_pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load),
    .load_pc (redirect_target),
    .incr    (pc_incr),
    .pc      (pc)
  );

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    ir_d         = ir_q;
    inst_pc_d    = inst_pc_q;
    pc_incr      = 1'b0;

    if (bus.redirect_valid) begin
      // Redirect overrides everything; a response landing this cycle is stale.
      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            drop_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = ST_FETCH;
          end else begin
            drop_d  = 1'b1;
          end
        end
        ST_HOLD: begin
          inst_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end
        ST_FAULT: begin
          state_d = ST_FETCH;
        end
      endcase
      if (redirect_bad) begin
        state_d      = ST_FAULT;
        drop_d       = 1'b0;
        inst_valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_FETCH;
            end else begin
              ir_d         = bus.imem_rsp_data;
              inst_pc_d    = pc;
              pc_incr      = 1'b1;
              inst_valid_d = 1'b1;
              state_d      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.inst_ready) begin
            inst_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
      endcase
    end

    // Request is registered, so it rises the cycle after entering FETCH.
    req_valid_d = (state_d == ST_FETCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      ir_q         <= NOP_INST;
      inst_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      ir_q         <= ir_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.instruction    = ir_q;
  assign bus.inst_pc        = inst_pc_q;
`ifdef MISALIGN_CHECK_EN
  assign bus.misalign_fault = (state_q == ST_FAULT);
`endif

endmodule

`default_nettype wire
